// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction, reads two sources, drives the ALU
// for a per-class latency, then writes C back. Build option: R0_HARDWIRED_EN.
module alu_issue_ctrl #(
    parameter int LOGIC_LAT = 1,
    parameter int SHIFT_LAT = 2,
    parameter int MUL_LAT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_ra_sel,
    output logic [3:0]  rf_rb_sel,
    input  logic [31:0] rf_ra_data,
    input  logic [31:0] rf_rb_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_op,
    input  logic [31:0] alu_c,
    output logic        rf_we,
    output logic [3:0]  rf_wsel,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [3:0] LOGIC_CNT = 4'(LOGIC_LAT - 1);
    localparam logic [3:0] SHIFT_CNT = 4'(SHIFT_LAT - 1);
    localparam logic [3:0] MUL_CNT   = 4'(MUL_LAT - 1);

    state_t      state;
    logic [31:0] ir;
    logic [3:0]  cnt;
    logic        opc_legal;
    logic [3:0]  opc_cnt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_en;
    logic        unused_ir;

    assign unused_ir = ^ir[14:0];
    assign dbg_state = state;

    always_comb begin
        opc_legal = 1'b1;
        opc_cnt   = LOGIC_CNT;
        case (ir[31:27])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT: opc_cnt = LOGIC_CNT;
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:       opc_cnt = SHIFT_CNT;
            OP_MUL:                                        opc_cnt = MUL_CNT;
            default:                                       opc_legal = 1'b0;
        endcase
    end

`ifdef R0_HARDWIRED_EN
    // R0 reads as zero and swallows writes; done still reports completion.
    assign src_a = (rf_ra_sel == 4'd0) ? 32'h0 : rf_ra_data;
    assign src_b = (rf_rb_sel == 4'd0) ? 32'h0 : rf_rb_data;
    assign wr_en = (ir[26:23] != 4'd0);
`else
    assign src_a = rf_ra_data;
    assign src_b = rf_rb_data;
    assign wr_en = 1'b1;
`endif

    // Handshake: an instruction transfers at a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only while idle, so instr is
    // ignored in every other state and a held instr_valid simply waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ir          <= '0;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rf_wdata    <= '0;
            rf_wsel     <= '0;
            rf_ra_sel   <= '0;
            rf_rb_sel   <= '0;
            rf_we       <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            busy        <= 1'b0;
            instr_ready <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    if (instr_valid && instr_ready) begin
                        ir          <= instr;
                        rf_ra_sel   <= instr[22:19];
                        rf_rb_sel   <= instr[18:15];
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (opc_legal) begin
                        state <= READ;
                    end else begin
                        illegal <= 1'b1;
                        state   <= FAULT;
                    end
                end
                FAULT: begin
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                READ: begin
                    alu_a  <= src_a;
                    alu_b  <= src_b;
                    alu_op <= {ir[31:27], 27'd0};
                    cnt    <= opc_cnt;
                    state  <= EXEC;
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rf_wdata <= alu_c;
                        rf_wsel  <= ir[26:23];
                        rf_we    <= wr_en;
                        done     <= 1'b1;
                        state    <= WB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WB: begin
                    alu_op      <= '0;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    instr_ready <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: register-file and ALU models, one task per scenario.
module tb_alu_issue_ctrl;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_ra_sel, rf_rb_sel, rf_wsel;
    logic [31:0] rf_ra_data, rf_rb_data, rf_wdata;
    logic [31:0] alu_a, alu_b, alu_op, alu_c;
    logic        rf_we, busy, done, illegal;
    logic [2:0]  dbg_state;

    logic [31:0] regs [0:15];
    int checks = 0;
    int errors = 0;

    logic        obs_we   [0:15];
    logic        obs_done [0:15];
    logic        obs_ill  [0:15];
    logic        obs_rdy  [0:15];
    logic [3:0]  obs_wsel [0:15];
    logic [31:0] obs_wdat [0:15];
    logic [31:0] obs_a    [0:15];
    logic [31:0] obs_b    [0:15];
    logic [31:0] obs_op   [0:15];

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_ra_sel(rf_ra_sel), .rf_rb_sel(rf_rb_sel),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_c(alu_c), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .rf_wdata(rf_wdata), .busy(busy), .done(done), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign rf_ra_data = regs[rf_ra_sel];
    assign rf_rb_data = regs[rf_rb_sel];

    always @(posedge clk) if (rf_we) regs[rf_wsel] <= rf_wdata;

    always_comb begin
        alu_c = 32'h0;
        case (alu_op[31:27])
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_SUB:  alu_c = alu_a - alu_b;
            OP_SHL:  alu_c = alu_a << alu_b[4:0];
            OP_OR:   alu_c = alu_a | alu_b;
            OP_MUL:  alu_c = alu_a * alu_b;
            default: alu_c = 32'h0;
        endcase
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    // Waits for instr_ready, offers ins, returns 1 time unit after the accepting edge E0.
    task automatic issue(input logic [31:0] ins, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout: instr_ready=%b required 1", instr_ready);
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    // Records outputs during the cycle after each edge E1..En.
    task automatic observe(input int n, input int drop);
        for (int k = 0; k < 16; k++) begin
            obs_we[k] = 1'b0; obs_done[k] = 1'b0; obs_ill[k] = 1'b0; obs_rdy[k] = 1'b0;
            obs_wsel[k] = '0; obs_wdat[k] = '0; obs_a[k] = '0; obs_b[k] = '0; obs_op[k] = '0;
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            obs_we[k] = rf_we;   obs_done[k] = done;     obs_ill[k] = illegal;
            obs_rdy[k] = instr_ready;
            obs_wsel[k] = rf_wsel; obs_wdat[k] = rf_wdata;
            obs_a[k] = alu_a;    obs_b[k] = alu_b;       obs_op[k] = alu_op;
            if (k == drop) instr_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({instr_ready, busy, rf_we, done, illegal} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: rdy/busy/we/done/ill=%b required 00000",
                     {instr_ready, busy, rf_we, done, illegal});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, rf_wdata} !== 128'h0 || {rf_wsel, rf_ra_sel, rf_rb_sel} !== 12'h0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h op=%h wd=%h required all 0", alu_a, alu_b, alu_op, rf_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b state=%0d required 1 0 0", instr_ready, busy, dbg_state);
        end
    endtask

    task automatic test_add();
        int nwe = 0;
        regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'h0;
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b0);
        observe(6, 0);
        for (int k = 1; k <= 6; k++) nwe += obs_we[k];
        checks++;
        if (obs_op[2][31:27] !== OP_ADD || obs_a[2] !== 32'd5 || obs_b[2] !== 32'd7) begin
            errors++;
            $display("FAIL add_exec_drive: op=%b a=%0d b=%0d required 00011 5 7", obs_op[2][31:27], obs_a[2], obs_b[2]);
        end
        checks++;
        if (obs_we[3] !== 1'b1 || nwe != 1) begin
            errors++;
            $display("FAIL add_we_timing: we_after_E3=%b we_count=%0d required 1 1", obs_we[3], nwe);
        end
        checks++;
        if (obs_wsel[3] !== 4'd3 || obs_wdat[3] !== 32'd12 || obs_done[3] !== 1'b1 || obs_done[2] !== 1'b0) begin
            errors++;
            $display("FAIL add_wb: wsel=%0d wdata=%0d done=%b required 3 12 1", obs_wsel[3], obs_wdat[3], obs_done[3]);
        end
        checks++;
        if (obs_rdy[3] !== 1'b0 || obs_rdy[4] !== 1'b1 || regs[3] !== 32'd12 || obs_op[4] !== 32'h0) begin
            errors++;
            $display("FAIL add_return: rdy3=%b rdy4=%b r3=%0d op4=%h required 0 1 12 0", obs_rdy[3], obs_rdy[4], regs[3], obs_op[4]);
        end
    endtask

    task automatic test_shl();
        int nwe = 0;
        regs[5] = 32'd1; regs[6] = 32'd4; regs[4] = 32'h0;
        issue(mk(OP_SHL, 4'd4, 4'd5, 4'd6), 1'b0);
        observe(7, 0);
        for (int k = 1; k <= 7; k++) nwe += obs_we[k];
        checks++;
        if (obs_a[2] !== 32'd1 || obs_a[3] !== 32'd1 || obs_b[2] !== 32'd4 || obs_b[3] !== 32'd4 ||
            obs_op[3][31:27] !== OP_SHL) begin
            errors++;
            $display("FAIL shl_stable: a=%0d,%0d b=%0d,%0d required 1,1 4,4", obs_a[2], obs_a[3], obs_b[2], obs_b[3]);
        end
        checks++;
        if (obs_we[4] !== 1'b1 || nwe != 1 || obs_wsel[4] !== 4'd4 || obs_wdat[4] !== 32'd16) begin
            errors++;
            $display("FAIL shl_wb: we4=%b count=%0d wsel=%0d wdata=%0d required 1 1 4 16",
                     obs_we[4], nwe, obs_wsel[4], obs_wdat[4]);
        end
        checks++;
        if (obs_rdy[4] !== 1'b0 || obs_rdy[5] !== 1'b1) begin
            errors++;
            $display("FAIL shl_ready: rdy4=%b rdy5=%b required 0 1", obs_rdy[4], obs_rdy[5]);
        end
    endtask

    task automatic test_illegal();
        int nwe = 0;
        int nill = 0;
        issue(mk(OP_DIV, 4'd2, 4'd1, 4'd2), 1'b0);
        observe(5, 0);
        for (int k = 1; k <= 5; k++) begin
            nwe += obs_we[k];
            nill += obs_ill[k];
        end
        checks++;
        if (obs_ill[1] !== 1'b1 || nill != 1 || nwe != 0) begin
            errors++;
            $display("FAIL illegal_pulse: ill1=%b ill_count=%0d we_count=%0d required 1 1 0", obs_ill[1], nill, nwe);
        end
        checks++;
        if (obs_rdy[1] !== 1'b0 || obs_rdy[2] !== 1'b1 || obs_op[1] !== 32'h0 || obs_op[2] !== 32'h0) begin
            errors++;
            $display("FAIL illegal_ready: rdy1=%b rdy2=%b op=%h required 0 1 0", obs_rdy[1], obs_rdy[2], obs_op[1]);
        end
    endtask

    task automatic test_back_to_back();
        int nwe = 0;
        regs[1] = 32'd9; regs[2] = 32'd4; regs[7] = 32'h0; regs[8] = 32'h0;
        issue(mk(OP_ADD, 4'd7, 4'd1, 4'd2), 1'b1);
        instr = mk(OP_SUB, 4'd8, 4'd1, 4'd2);
        observe(10, 5);
        for (int k = 1; k <= 10; k++) nwe += obs_we[k];
        checks++;
        if (obs_we[3] !== 1'b1 || obs_wdat[3] !== 32'd13 || obs_wsel[3] !== 4'd7) begin
            errors++;
            $display("FAIL b2b_first: we=%b wdata=%0d wsel=%0d required 1 13 7", obs_we[3], obs_wdat[3], obs_wsel[3]);
        end
        checks++;
        if (obs_we[8] !== 1'b1 || obs_wdat[8] !== 32'd5 || obs_wsel[8] !== 4'd8 || nwe != 2) begin
            errors++;
            $display("FAIL b2b_second: we8=%b wdata=%0d wsel=%0d count=%0d required 1 5 8 2",
                     obs_we[8], obs_wdat[8], obs_wsel[8], nwe);
        end
        checks++;
        if (obs_rdy[3] !== 1'b0 || obs_rdy[4] !== 1'b1 || obs_rdy[5] !== 1'b0 || regs[7] !== 32'd13 || regs[8] !== 32'd5) begin
            errors++;
            $display("FAIL b2b_accept: rdy3/4/5=%b%b%b r7=%0d r8=%0d required 010 13 5",
                     obs_rdy[3], obs_rdy[4], obs_rdy[5], regs[7], regs[8]);
        end
    endtask

    task automatic test_reset_mid();
        int nwe = 0;
        regs[1] = 32'd9; regs[2] = 32'd4; regs[9] = 32'hDEAD; regs[10] = 32'h0;
        issue(mk(OP_MUL, 4'd9, 4'd1, 4'd2), 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op} !== 96'h0 || {busy, instr_ready, rf_we, done} !== 4'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_async: a=%h b=%h op=%h busy=%b state=%0d required all 0",
                     alu_a, alu_b, alu_op, busy, dbg_state);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            nwe += rf_we;
        end
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (nwe != 0 || regs[9] !== 32'hDEAD) begin
            errors++;
            $display("FAIL reset_mid_nowrite: we_count=%0d r9=%h required 0 dead", nwe, regs[9]);
        end
        issue(mk(OP_ADD, 4'd10, 4'd1, 4'd2), 1'b0);
        observe(5, 0);
        checks++;
        if (obs_we[3] !== 1'b1 || obs_wdat[3] !== 32'd13 || obs_wsel[3] !== 4'd10 || regs[10] !== 32'd13) begin
            errors++;
            $display("FAIL reset_mid_recover: we=%b wdata=%0d wsel=%0d r10=%0d required 1 13 10 13",
                     obs_we[3], obs_wdat[3], obs_wsel[3], regs[10]);
        end
    endtask

    task automatic test_r0();
        int nwe = 0;
        int ndone = 0;
        regs[0] = 32'h5A; regs[2] = 32'hA5;
        issue(mk(OP_OR, 4'd0, 4'd0, 4'd2), 1'b0);
        observe(6, 0);
        for (int k = 1; k <= 6; k++) begin
            nwe += obs_we[k];
            ndone += obs_done[k];
        end
`ifdef R0_HARDWIRED_EN
        checks++;
        if (obs_a[2] !== 32'h0 || obs_b[2] !== 32'hA5) begin
            errors++;
            $display("FAIL r0_read: a=%h b=%h required 0 a5", obs_a[2], obs_b[2]);
        end
        checks++;
        if (obs_done[3] !== 1'b1 || ndone != 1 || nwe != 0 || regs[0] !== 32'h5A) begin
            errors++;
            $display("FAIL r0_write: done3=%b done_count=%0d we_count=%0d r0=%h required 1 1 0 5a",
                     obs_done[3], ndone, nwe, regs[0]);
        end
`else
        checks++;
        if (obs_a[2] !== 32'h5A || obs_b[2] !== 32'hA5) begin
            errors++;
            $display("FAIL r0_read: a=%h b=%h required 5a a5", obs_a[2], obs_b[2]);
        end
        checks++;
        if (obs_we[3] !== 1'b1 || nwe != 1 || ndone != 1 || obs_wsel[3] !== 4'd0 || regs[0] !== 32'hFF) begin
            errors++;
            $display("FAIL r0_write: we3=%b we_count=%0d wsel=%0d r0=%h required 1 1 0 ff",
                     obs_we[3], nwe, obs_wsel[3], regs[0]);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        test_reset();
        test_add();
        test_shl();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_r0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operation interface: accepts one instruction word at a time over a valid/ready handshake.
- Decodes the opcode and register fields, reads two source registers from the register file, and drives A, B and op into the ALU.
- Holds A, B and op stable for a per-class latency, captures C, then writes the result back to the register file.
- Sits between instruction fetch/control and the ALU/register file.

Parameters:
- LOGIC_LAT, 1: EXEC cycles for ADD, SUB, AND, OR, NOT, NEG (legal range 1..15).
- SHIFT_LAT, 2: EXEC cycles for SHR, SHRA, SHL, ROR, ROL (legal range 1..15).
- MUL_LAT, 4: EXEC cycles for MUL (legal range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction word offered.
- instr  in  32  [31:27] opcode, [26:23] Ra (dest), [22:19] Rb (src A), [18:15] Rc (src B).
- instr_ready  out  1  controller can accept an instruction.
- rf_ra_sel  out  4  register-file read select, port A.
- rf_rb_sel  out  4  register-file read select, port B.
- rf_ra_data  in  32  combinational read data, port A.
- rf_rb_data  in  32  combinational read data, port B.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  32  ALU op word; opcode in [31:27].
- alu_c  in  32  ALU result.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_wsel  out  4  write select.
- rf_wdata  out  32  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with rf_we.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. ir, alu_a, alu_b, alu_op, rf_wdata, rf_wsel, rf_ra_sel, rf_rb_sel and the latency counter all clear to 0. rf_we, done, illegal, busy=0. instr_ready=1 once reset deasserts.
- Reset mid-operation aborts the instruction with no write. Release from reset is synchronous to clk.
- instr_ready=1 only in IDLE. A transfer happens at an edge where instr_valid & instr_ready. instr is latched into ir and the state moves to DECODE. instr is ignored in every other state.
- DECODE (1 cycle):
  - rf_ra_sel=ir[22:19], rf_rb_sel=ir[18:15].
  - Legal opcodes: 00011 ADD, 00100 SUB, 00101 SHR, 00110 SHRA, 00111 SHL, 01000 ROR, 01001 ROL, 01010 AND, 01011 OR, 01111 MUL, 10001 NEG, 10010 NOT.
  - Any other opcode: illegal=1 for the next cycle, return to IDLE, no write, no ALU drive.
  - Legal opcode: go to READ.
- READ (1 cycle): register rf_ra_data into alu_a and rf_rb_data into alu_b. alu_op=ir with bits [26:0] forced to 0. Load counter=class latency-1. Go to EXEC.
- EXEC (lat cycles): alu_a, alu_b and alu_op stay stable. The counter decrements each cycle. At the edge where counter==0, capture alu_c into rf_wdata, set rf_wsel=ir[26:23], and go to WB.
- WB (1 cycle): rf_we=1, done=1. Next state is IDLE, where alu_op returns to 0. alu_a and alu_b hold their last values.
- Timing: with the handshake at edge E0, rf_we is high during the cycle after edge E(2+lat). IDLE (instr_ready=1) follows at E(3+lat). Throughput is one instruction per lat+4 cycles.
- Arithmetic is entirely inside the ALU. The controller never modifies data. MUL writes back only the 32-bit C.
- Ra==Rb or Ra==Rc is legal; sources are read before the write.
- A held instr_valid in WB is not accepted until IDLE.

Optional Feature:
- Macro: R0_HARDWIRED_EN.
- Defined:
  - A source select of 0 substitutes 32'h0 for that register-file data when alu_a/alu_b are loaded in READ.
  - Destination Ra==0 completes the full sequence but keeps rf_we=0. done still pulses.
- Undefined: R0 is an ordinary register for both reads and writes.

Test Plan:
- ADD R3,R1,R2 with R1=5, R2=7 -> alu_op[31:27]=00011 during EXEC; rf_we high exactly 1 cycle with rf_wsel=3 and rf_wdata=12, in the cycle after edge E3; done coincident.
- SHL R4,R5,R6 with SHIFT_LAT=2, ALU model valid 2 cycles after inputs, R5=1, R6=4 -> alu_a/alu_b stable 2 cycles; rf_wdata=16 at rf_wsel=4, in the cycle after edge E4.
- Opcode 10000 (DIV) -> illegal pulses 1 cycle, rf_we never asserts, instr_ready returns to 1 at edge E2.
- instr_valid held high for back-to-back ADD then SUB (R1=9, R2=4) -> second accepted only in IDLE after the first WB; writes are 13, then 5.
- reset driven low during EXEC of a MUL -> all outputs 0 immediately (asynchronously), no rf_we; after release, a new ADD completes normally.
- With R0_HARDWIRED_EN, OR R0,R0,R2 with R2=0xA5 -> alu_a=0; done pulses, rf_we stays 0. Without the macro, R0 is written with 0xA5 | R0 contents.
